// File: rtl/fifo_core.sv
// fifo_core: single-clock FIFO with write ack, overflow/underflow pulses and count-derived status flags
// Ports: clk, rst_n (async active-low); data_in/wr_en write side; rd_en/data_out read side (1-cycle latency);
//        wr_ack/overflow/underflow registered per-request pulses; full/almostfull/empty/almostempty from count.
module fifo_core #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack, r_overflow, r_underflow;
  logic                  w_wr, w_rd;
  assign full        = r_count == DEPTH;
  assign almostfull  = r_count == DEPTH - CW'(1);
  assign empty       = r_count == '0;
  assign almostempty = r_count == CW'(1);
  assign w_wr        = wr_en && !full;
  assign w_rd        = rd_en && !empty;
  assign data_out    = r_data_out;
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  // storage is never reset; stale words become unreachable once pointers/count clear
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= data_in;
  // pointers wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr ? (r_wr_ptr == LAST ? '0 : r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_rd_ptr    <= w_rd ? (r_rd_ptr == LAST ? '0 : r_rd_ptr + AW'(1)) : r_rd_ptr;
      r_count     <= (w_wr && !w_rd) ? r_count + CW'(1) : (w_rd && !w_wr) ? r_count - CW'(1) : r_count;
      r_data_out  <= w_rd ? r_mem[r_rd_ptr] : r_data_out;
      r_wr_ack    <= w_wr;
      r_overflow  <= wr_en && full;
      r_underflow <= rd_en && empty;
    end
endmodule

// File: doc/fifo_core.md
Name: fifo_core

Overview:
- Synchronous single-clock FIFO with handshake and status flags; this is the design under test whose pins the FIFO_IF monitor samples every negative clock edge.
- Buffers FIFO_DEPTH words of FIFO_WIDTH bits.
- Reports write acknowledge, overflow, underflow, and full / empty / almost-full / almost-empty status so the scoreboard and coverage collectors can check it cycle by cycle.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries. Must be ≥ 4; any value is legal (not restricted to powers of 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected because the FIFO was full.
- underflow  output  1  registered; previous-cycle read rejected because the FIFO was empty.
- full  output  1  combinational; count == FIFO_DEPTH.
- almostfull  output  1  combinational; count == FIFO_DEPTH-1.
- empty  output  1  combinational; count == 0.
- almostempty  output  1  combinational; count == 1.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits.
  - count, $clog2(FIFO_DEPTH)+1 bits.
  - mem[FIFO_DEPTH].
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Resulting flags: empty=1, full=0, almostfull=0, almostempty=0.
  - mem contents are not cleared but are unreachable.
  - Reset asserted mid-operation discards all stored words; the first read after reset returns only data written after reset.
- Write decision each rising edge (evaluated on pre-edge count):
  - wr_en=1 and count<FIFO_DEPTH → mem[wr_ptr]<=data_in; wr_ptr advances, wrapping FIFO_DEPTH-1→0; wr_ack<=1; overflow<=0.
  - wr_en=1 and count==FIFO_DEPTH → nothing stored; wr_ack<=0; overflow<=1.
  - wr_en=0 → wr_ack<=0; overflow<=0.
- Read decision each rising edge (evaluated on pre-edge count):
  - rd_en=1 and count>0 → data_out<=mem[rd_ptr]; rd_ptr advances with wrap; underflow<=0.
  - rd_en=1 and count==0 → data_out holds; underflow<=1.
  - rd_en=0 → data_out holds; underflow<=0.
- Read latency: one cycle. Data is visible on data_out after the rising edge that accepts the read.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both succeed; count unchanged.
  - Empty: write succeeds, read is rejected (underflow=1); count becomes 1.
  - Full: read succeeds, write is rejected (overflow=1); count becomes FIFO_DEPTH-1.
  - No write-through: a word written this edge is never read on the same edge.
- count update: +1 on write-only success, −1 on read-only success, otherwise unchanged. count never exceeds FIFO_DEPTH and never goes below 0.
- Pulse width: wr_ack, overflow and underflow are single-cycle pulses per request. They stay high across consecutive requests when the condition persists.
- Flags derive only from count, so they change on the same rising edge as count.

Test Plan:
- Reset then idle → after rst_n deassert: empty=1, almostempty=0, full=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
- Write 8 words 0x0001..0x0008 back-to-back →
  - wr_ack=1 on each of the 8 following cycles.
  - almostfull=1 after the 7th write; full=1 after the 8th.
  - A 9th write gives overflow=1, wr_ack=0, and the FIFO contents are unchanged.
- From full, read 8 times → data_out sequence 0x0001..0x0008 (one cycle after each rd_en); almostempty=1 after the 7th read; empty=1 after the 8th; a 9th read gives underflow=1 and data_out stays 0x0008.
- Simultaneous wr_en=rd_en=1:
  - When empty: count becomes 1, underflow=1, wr_ack=1.
  - When full: count becomes 7, overflow=1, data_out = oldest word.
  - With count=4: count stays 4, wr_ack=1.
- Wrap-around: 20 cycles of interleaved write/read with data 0xA000+i → every word read back in order (0xA000, 0xA001, ...) across pointer wrap, with no overflow and no underflow.
- Assert rst_n=0 mid-stream with count=5, asynchronously between edges → outputs clear immediately; after release, a write of 0x1234 followed by a read returns 0x1234.
